seven_segment_scanner: RTL and testbench

Parametrised multiplexed driver for common-anode seven-segment banks: scans `NUM_DIGITS` hex digits with per-digit decimal points, per-digit blanking, optional leading-zero suppression and PWM brightness. Display data is double-buffered and swapped only at frame boundaries, so a value update never tears mid-scan. It sits between any debug/status producer and the board's `cat`/`an`/`dp` pins, and supersedes fixed 8-digit, 32-bit scanning.

---
 rtl/seven_segment_scanner_if.sv | 24 ++
 rtl/seven_segment_scanner.sv | 85 ++++++++
 tb/tb_seven_segment_scanner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// seven_segment_scanner_if: display data/control inputs and cathode/anode outputs of the scanner
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W = 4
);
  logic [4*NUM_DIGITS-1:0] val_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [NUM_DIGITS-1:0] blank_in;
  logic lz_en_in;
  logic [BRIGHT_W-1:0] brightness_in;
  logic load_in;
  logic frame_out;
  logic [6:0] cat_out;
  logic dp_out;
  logic [NUM_DIGITS-1:0] an_out;
  modport master (
    output val_in, dp_in, blank_in, lz_en_in, brightness_in, load_in,
    input frame_out, cat_out, dp_out, an_out
  );
  modport slave (
    input val_in, dp_in, blank_in, lz_en_in, brightness_in, load_in,
    output frame_out, cat_out, dp_out, an_out
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed hex display driver with frame-aligned double buffering, LZ suppression and PWM dimming
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int COUNT_TO = 100_000,
  parameter int BRIGHT_W = 4
) (
  input logic clk_in,
  input logic rst_in,
  seven_segment_scanner_if.slave bus
);
  localparam int SW = $clog2(COUNT_TO + 1);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_MAX = SW'(COUNT_TO);
  localparam logic [DW-1:0] DIG_MAX = DW'(NUM_DIGITS - 1);
  // active-high segment patterns, glyph n at bits [7n+6:7n]
  localparam logic [111:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  logic [SW-1:0] r_slot;
  logic [DW-1:0] r_digit;
  logic [BRIGHT_W-1:0] r_pwm;
  logic [4*NUM_DIGITS-1:0] r_pend_val, r_act_val;
  logic [NUM_DIGITS-1:0] r_pend_dp, r_pend_blank, r_act_dp, r_act_blank;
  logic r_pend_valid;
  logic [6:0] r_cat;
  logic r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic w_slot_end, w_boundary, w_on, w_sup, w_blank;
  logic [NUM_DIGITS-1:0] w_upper_nz;
  logic [3:0] w_nib;

  // w_upper_nz[i]: some nibble at position i or above is non-zero
  always_comb begin
    w_upper_nz = '0;
    w_upper_nz[NUM_DIGITS-1] = |r_act_val[4*NUM_DIGITS-1 -: 4];
    for (int j = NUM_DIGITS - 2; j >= 0; j--) w_upper_nz[j] = w_upper_nz[j+1] | (|r_act_val[4*j +: 4]);
  end

  assign w_slot_end = r_slot == SLOT_MAX;
  assign w_boundary = w_slot_end && r_digit == DIG_MAX;
  assign w_nib = r_act_val[{r_digit, 2'b00} +: 4];
  assign w_blank = r_act_blank[r_digit];
  assign w_sup = bus.lz_en_in && r_digit != '0 && !w_upper_nz[r_digit];
  assign w_on = (&bus.brightness_in) || r_pwm < bus.brightness_in;

  assign bus.frame_out = w_boundary;
  assign bus.cat_out = r_cat;
  assign bus.dp_out = r_dp;
  assign bus.an_out = r_an;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_slot <= '0;
      r_digit <= '0;
      r_pwm <= '0;
      r_pend_val <= '0;
      r_pend_dp <= '0;
      r_pend_blank <= '0;
      r_pend_valid <= 1'b0;
      r_act_val <= '0;
      r_act_dp <= '0;
      r_act_blank <= '0;
      r_cat <= 7'h7F;
      r_dp <= 1'b1;
      r_an <= '1;
    end else begin
      r_slot <= w_slot_end ? '0 : r_slot + 1'b1;
      if (w_slot_end) r_digit <= r_digit == DIG_MAX ? '0 : r_digit + 1'b1;
      r_pwm <= r_pwm + 1'b1;
      // a load landing on the boundary bypasses the pending copy
      if (w_boundary) begin
        r_pend_valid <= 1'b0;
        if (bus.load_in) {r_act_val, r_act_dp, r_act_blank} <= {bus.val_in, bus.dp_in, bus.blank_in};
        else if (r_pend_valid) {r_act_val, r_act_dp, r_act_blank} <= {r_pend_val, r_pend_dp, r_pend_blank};
      end else if (bus.load_in) begin
        {r_pend_val, r_pend_dp, r_pend_blank} <= {bus.val_in, bus.dp_in, bus.blank_in};
        r_pend_valid <= 1'b1;
      end
      r_cat <= (w_blank || w_sup) ? 7'h7F : ~GLYPHS[7*w_nib +: 7];
      r_dp <= w_blank | ~r_act_dp[r_digit];
      r_an <= (w_blank || !w_on) ? '1 : ~(NUM_DIGITS'(1) << r_digit);
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed checks of scan order, buffering, LZ, blanking, PWM and reset
module tb_seven_segment_scanner;
  localparam logic [6:0] C0 = 7'h40, C1 = 7'h79, C2 = 7'h24, C3 = 7'h30, C4 = 7'h19;
  localparam logic [6:0] C5 = 7'h12, C8 = 7'h00, CF = 7'h0E, BL = 7'h7F;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;

  seven_segment_scanner_if #(.NUM_DIGITS(4), .BRIGHT_W(2)) bus ();
  seven_segment_scanner #(.NUM_DIGITS(4), .COUNT_TO(3), .BRIGHT_W(2)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus.val_in = v;
    bus.dp_in = dp;
    bus.blank_in = bl;
    bus.load_in = 1'b1;
    @(negedge clk);
    bus.load_in = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_out && n < 64);
    if (!bus.frame_out) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  // entered on the boundary cycle; checks the 16 cycles of the following frame
  task automatic scan(input string tag, input logic [27:0] cats, input logic [3:0] dps,
                      input logic [3:0] dark, input logic [3:0] an_mask,
                      input logic do_ld, input logic [15:0] ld_val);
    logic [3:0] exp_an;
    @(negedge clk);
    bus.load_in = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      int d;
      d = k / 4;
      if (k > 0) @(negedge clk);
      exp_an = dark[d] ? 4'hF : ~(4'b0001 << d);
      chk({tag, "_cat"}, 32'(bus.cat_out), 32'(cats[7*d +: 7]));
      chk({tag, "_dp"}, 32'(bus.dp_out), 32'(dps[d]));
      if (an_mask[d]) chk({tag, "_an"}, 32'(bus.an_out), 32'(exp_an));
      chk({tag, "_frame"}, 32'(bus.frame_out), 32'(k == 14));
      bus.load_in = do_ld && k == 5;
      if (do_ld && k == 5) bus.val_in = ld_val;
    end
    @(negedge clk);
    bus.load_in = 1'b0;
  endtask

  task automatic bright(input logic [1:0] b, input int exp);
    int lows = 0;
    bus.brightness_in = b;
    wait_frame();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.an_out != 4'hF) lows++;
    end
    chk("bright_lows", 32'(lows), 32'(exp));
  endtask

  initial begin
    bus.val_in = '0;
    bus.dp_in = '0;
    bus.blank_in = '0;
    bus.lz_en_in = 1'b0;
    bus.brightness_in = 2'd3;
    bus.load_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.an_out), 32'hF);
    chk("rst_cat", 32'(bus.cat_out), 32'h7F);
    chk("rst_dp", 32'(bus.dp_out), 32'd1);
    chk("rst_frame", 32'(bus.frame_out), 32'd0);
    rst = 1'b0;
    load(16'h8F10, 4'h0, 4'h0);
    wait_frame();
    scan("basic", {C8, CF, C1, C0}, 4'hF, 4'h0, 4'hF, 1'b0, 16'h0);
    load(16'h1111, 4'h0, 4'h0);
    wait_frame();
    scan("tear_old", {C1, C1, C1, C1}, 4'hF, 4'h0, 4'hF, 1'b1, 16'h2222);
    wait_frame();
    scan("tear_new", {C2, C2, C2, C2}, 4'hF, 4'h0, 4'hF, 1'b0, 16'h0);
    wait_frame();
    bus.val_in = 16'h3333;
    bus.load_in = 1'b1;
    scan("bnd_load", {C3, C3, C3, C3}, 4'hF, 4'h0, 4'hF, 1'b1, 16'h4444);
    wait_frame();
    bus.val_in = 16'h2222;
    bus.load_in = 1'b1;
    scan("bnd_over", {C2, C2, C2, C2}, 4'hF, 4'h0, 4'hF, 1'b0, 16'h0);
    wait_frame();
    scan("bnd_stale", {C2, C2, C2, C2}, 4'hF, 4'h0, 4'hF, 1'b0, 16'h0);
    bus.lz_en_in = 1'b1;
    load(16'h0050, 4'b1000, 4'h0);
    wait_frame();
    scan("lz", {BL, BL, C5, C0}, 4'b0111, 4'h0, 4'b1011, 1'b0, 16'h0);
    load(16'h0000, 4'h0, 4'h0);
    wait_frame();
    scan("lz_zero", {BL, BL, BL, C0}, 4'hF, 4'h0, 4'b0001, 1'b0, 16'h0);
    bus.lz_en_in = 1'b0;
    load(16'h4321, 4'hF, 4'b0100);
    wait_frame();
    scan("blank", {C4, BL, C2, C1}, 4'b0100, 4'b0100, 4'hF, 1'b0, 16'h0);
    load(16'h8F10, 4'h0, 4'h0);
    wait_frame();
    bright(2'd1, 4);
    bright(2'd0, 0);
    bright(2'd2, 8);
    bright(2'd3, 16);
    wait_frame();
    repeat (3) @(negedge clk);
    load(16'hABCD, 4'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", 32'(bus.an_out), 32'hF);
    chk("mid_rst_cat", 32'(bus.cat_out), 32'h7F);
    chk("mid_rst_frame", 32'(bus.frame_out), 32'd0);
    rst = 1'b0;
    wait_frame();
    scan("post_rst", {C0, C0, C0, C0}, 4'hF, 4'h0, 4'hF, 1'b0, 16'h0);
    wait_frame();
    scan("post_rst2", {C0, C0, C0, C0}, 4'hF, 4'h0, 4'hF, 1'b0, 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
